// File: rtl/seg7_pkg.sv
// Shared constants, types and the hex decoder for the result display.
// Segment order is {g,f,e,d,c,b,a}, all active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;
    localparam logic [3:0] AN_DIGIT0 = 4'b1110;
    localparam logic [3:0] AN_DIGIT1 = 4'b1101;
    localparam logic [3:0] AN_DIGIT2 = 4'b1011;
    localparam logic [3:0] AN_DIGIT3 = 4'b0111;

    typedef enum logic [1:0] {
        ACC0_LO = 2'b00,
        ACC0_HI = 2'b01,
        ACC1_LO = 2'b10,
        ACC1_HI = 2'b11
    } disp_sel_e;

    function automatic logic [3:0] an_onehot_low(input logic [1:0] digit);
        logic [3:0] an;
        case (digit)
            2'd0:    an = AN_DIGIT0;
            2'd1:    an = AN_DIGIT1;
            2'd2:    an = AN_DIGIT2;
            default: an = AN_DIGIT3;
        endcase
        return an;
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_result_display_if.sv
// Accumulator result bus from the TPU debug outputs plus the board controls.
interface seg7_result_display_if;
    logic signed [31:0] acc0;
    logic signed [31:0] acc1;
    logic               acc_valid;
    logic [1:0]         sel;
    logic               hold;

    modport master (output acc0, acc1, acc_valid, sel, hold);
    modport slave  (input  acc0, acc1, acc_valid, sel, hold);
endinterface

// File: rtl/seg7_scan_timer.sv
// Digit scan timer: slot counter, digit index, blanking window and frame tick.
module seg7_scan_timer #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    output logic [1:0] digit,
    output logic       blank,
    output logic       frame_tick
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    logic [CW-1:0] slot_cnt;
    logic          slot_wrap;

    assign slot_wrap  = (slot_cnt == CW'(DIGIT_CYCLES - 1));
    assign blank      = (slot_cnt < CW'(BLANK_CYCLES));
    assign frame_tick = slot_wrap && (digit == 2'd3);

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            slot_cnt <= '0;
            digit    <= 2'd0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            digit    <= digit + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_result_display.sv
// Captures TPU accumulator results and shows one selected 16-bit half as hex
// on the four-digit multiplexed display, with sign and "new result" dots.
module seg7_result_display
    import seg7_pkg::*;
#(
    parameter int CLOCK_FREQ   = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 1000,
    parameter int FRESH_FRAMES = 250
) (
    input  logic                  clk_100mhz,
    input  logic                  rst,
    seg7_result_display_if.slave  acc_bus,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [3:0]            an
);

    localparam int DIGIT_CYCLES = CLOCK_FREQ / REFRESH_HZ;

    logic [1:0]         digit;
    logic               blank;
    logic               frame_tick;

    logic signed [31:0] shadow0;
    logic signed [31:0] shadow1;
    logic [15:0]        disp_word;
    logic               disp_sign;
    logic [7:0]         fresh_cnt;

    logic               capture;
    logic [15:0]        sel_word;
    logic               sel_sign;
    logic [3:0]         nibble;

    seg7_scan_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .digit      (digit),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    assign capture = acc_bus.acc_valid && !acc_bus.hold;

    // Selection reads the shadows, so a capture coinciding with a frame tick
    // is latched for display one frame later.
    always_comb begin
        sel_word = shadow0[15:0];
        sel_sign = shadow0[31];
        case (disp_sel_e'(acc_bus.sel))
            ACC0_LO: begin sel_word = shadow0[15:0];  sel_sign = shadow0[31]; end
            ACC0_HI: begin sel_word = shadow0[31:16]; sel_sign = shadow0[31]; end
            ACC1_LO: begin sel_word = shadow1[15:0];  sel_sign = shadow1[31]; end
            ACC1_HI: begin sel_word = shadow1[31:16]; sel_sign = shadow1[31]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            shadow0   <= '0;
            shadow1   <= '0;
            disp_word <= '0;
            disp_sign <= 1'b0;
            fresh_cnt <= '0;
        end else begin
            if (capture) begin
                shadow0 <= acc_bus.acc0;
                shadow1 <= acc_bus.acc1;
            end
            if (frame_tick) begin
                disp_word <= sel_word;
                disp_sign <= sel_sign;
            end
            if (capture)
                fresh_cnt <= 8'(FRESH_FRAMES);
            else if (frame_tick && (fresh_cnt != 8'd0))
                fresh_cnt <= fresh_cnt - 8'd1;
        end
    end

    always_comb begin
        case (digit)
            2'd0:    nibble = disp_word[3:0];
            2'd1:    nibble = disp_word[7:4];
            2'd2:    nibble = disp_word[11:8];
            default: nibble = disp_word[15:12];
        endcase
    end

    // Output stage: pins follow the scan state of the previous cycle. The dot
    // is dark during blanking along with the segments.
    always_ff @(posedge clk_100mhz) begin
        if (rst || blank) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_onehot_low(digit);
            seg <= hex_to_seg(nibble);
            case (digit)
                2'd3:    dp <= ~disp_sign;
                2'd0:    dp <= (fresh_cnt == 8'd0);
                default: dp <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_result_display.sv
// Bench for seg7_result_display: time-indexed reference model plus directed
// literal checks of the decoder, select, sign, hold and fresh-dot behaviour.
module tb_seg7_result_display;

    localparam int DC = 10;
    localparam int BC = 2;
    localparam int FF = 3;
    localparam int FRAME = 4 * DC;

    logic       clk_100mhz = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    seg7_result_display_if bus ();

    seg7_result_display #(
        .CLOCK_FREQ   (1000),
        .REFRESH_HZ   (100),
        .BLANK_CYCLES (BC),
        .FRESH_FRAMES (FF)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .acc_bus    (bus),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int checks = 0;
    int errors = 0;

    // Standard active-low hex glyphs {g..a}, indexed by nibble value.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: time since reset release, shadows, latched word and counters.
    int          cyc;
    logic [31:0] m_sh0, m_sh1, m_word;
    logic [15:0] m_disp;
    logic        m_sign;
    int          m_fresh;
    int          m_slot, m_dig;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    bit          model_live = 1'b0;

    always @(posedge clk_100mhz) begin
        if (rst) begin
            cyc = 0; m_sh0 = 0; m_sh1 = 0; m_disp = 0; m_sign = 0; m_fresh = 0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            model_live = 1'b1;
        end else begin
            m_slot = cyc % DC;
            m_dig  = (cyc / DC) % 4;
            if (m_slot < BC) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an  = ~(4'b0001 << m_dig);
                exp_seg = glyph[(m_disp >> (4 * m_dig)) & 16'hF];
                if (m_dig == 3)      exp_dp = ~m_sign;
                else if (m_dig == 0) exp_dp = (m_fresh == 0);
                else                 exp_dp = 1'b1;
            end
            if (m_slot == DC - 1 && m_dig == 3) begin
                m_word = bus.sel[1] ? m_sh1 : m_sh0;
                m_disp = bus.sel[0] ? m_word[31:16] : m_word[15:0];
                m_sign = m_word[31];
                if (m_fresh > 0) m_fresh = m_fresh - 1;
            end
            if (bus.acc_valid && !bus.hold) begin
                m_sh0 = bus.acc0; m_sh1 = bus.acc1; m_fresh = FF;
            end
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, expv);
        end
    endtask

    always @(negedge clk_100mhz) begin
        if (model_live) begin
            check("model_an", {3'b0, an}, {3'b0, exp_an});
            check("model_seg", seg, exp_seg);
            check("model_dp", {6'b0, dp}, {6'b0, exp_dp});
        end
    end

    task automatic wait_digit(input int d);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk_100mhz);
            if (an == ~(4'b0001 << d)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_digit%0d: an=%b never selected digit", d, an);
        end
    endtask

    task automatic pulse(input logic [31:0] a0, input logic [31:0] a1);
        bus.acc0 = a0; bus.acc1 = a1; bus.acc_valid = 1'b1;
        @(negedge clk_100mhz);
        bus.acc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_100mhz);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.acc0 = 0; bus.acc1 = 0; bus.acc_valid = 1'b0; bus.sel = 2'b00; bus.hold = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(13);
        // Reset in the middle of a visible digit-1 slot
        rst = 1'b1;
        @(negedge clk_100mhz);
        check("rst_an", {3'b0, an}, 7'h0F);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", {6'b0, dp}, 7'd1);
        rst = 1'b0;
        wait_digit(0);
        check("post_rst_d0", seg, 7'b1000000);

        pulse(32'h0000_A18F, 32'h0);
        wait_digit(0);
        check("fresh_lit", {6'b0, dp}, 7'd0);
        idle(FRAME + 5);
        wait_digit(3); check("a18f_d3", seg, 7'b0001000); check("a18f_dp3", {6'b0, dp}, 7'd1);
        wait_digit(2); check("a18f_d2", seg, 7'b1111001);
        wait_digit(1); check("a18f_d1", seg, 7'b0000000);
        wait_digit(0); check("a18f_d0", seg, 7'b0001110);

        bus.sel = 2'b11;
        pulse(32'h0, 32'hF000_0001);
        idle(FRAME + 5);
        wait_digit(3); check("f000_d3", seg, 7'b0001110); check("f000_dp3", {6'b0, dp}, 7'd0);
        wait_digit(0); check("f000_d0", seg, 7'b1000000);
        bus.sel = 2'b10;
        idle(FRAME + 5);
        wait_digit(3); check("0001_d3", seg, 7'b1000000); check("0001_dp3", {6'b0, dp}, 7'd0);
        wait_digit(0); check("0001_d0", seg, 7'b1111001);

        // Capture on the frame-tick cycle: old word this frame, new one next
        bus.sel = 2'b00;
        pulse(32'h0000_1234, 32'h0);
        idle(FRAME + 5);
        while ((cyc % FRAME) != FRAME - 1) @(negedge clk_100mhz);
        pulse(32'h0000_5678, 32'h0);
        wait_digit(3); check("coinc_old", seg, 7'b1111001);
        idle(DC);
        wait_digit(3); check("coinc_new", seg, 7'b0010010);
        idle(4 * FRAME + 10);
        wait_digit(0); check("fresh_off", {6'b0, dp}, 7'd1);

        bus.hold = 1'b1;
        pulse(32'h0000_FFFF, 32'h0);
        idle(FRAME + 5);
        wait_digit(3); check("hold_d3", seg, 7'b0010010);
        wait_digit(0); check("hold_fresh", {6'b0, dp}, 7'd1);
        bus.hold = 1'b0;
        pulse(32'h0000_9ABC, 32'h0);
        idle(FRAME + 5);
        wait_digit(3); check("release_d3", seg, 7'b0010000);

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk_100mhz);
            bus.acc_valid = ($urandom_range(0, 7) == 0);
            bus.acc0 = $urandom;
            bus.acc1 = $urandom;
            if ($urandom_range(0, 29) == 0) bus.sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) bus.hold = ~bus.hold;
            rst = ($urandom_range(0, 799) == 0);
        end
        rst = 1'b0;
        bus.acc_valid = 1'b0;
        idle(FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
